// File: rtl/sfu_pkg.sv
// Shared types and default sizing for the SFU accumulation stage.
package sfu_pkg;

    localparam int DEF_COL      = 8;
    localparam int DEF_PSUM_BW  = 16;
    localparam int DEF_ROWS     = 16;
    localparam int DEF_NUM_PASS = 9;

    typedef logic signed [DEF_PSUM_BW-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } sfu_state_t;

endpackage

// File: rtl/sfu_lane.sv
// One lane of the SFU datapath: signed saturating add and ReLU, purely combinational.
module sfu_lane #(
    parameter int PSUM_BW = sfu_pkg::DEF_PSUM_BW
) (
    input  logic [PSUM_BW-1:0] acc,
    input  logic [PSUM_BW-1:0] addend,
    output logic [PSUM_BW-1:0] sum,
    input  logic [PSUM_BW-1:0] relu_in,
    output logic [PSUM_BW-1:0] relu_out
);

    logic [PSUM_BW:0] wide;

    // Sign-extend by one bit, add, and clamp when the two top bits disagree.
    always_comb begin
        wide = {acc[PSUM_BW-1], acc} + {addend[PSUM_BW-1], addend};
        if (wide[PSUM_BW] != wide[PSUM_BW-1]) begin
            sum = wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                : {1'b0, {(PSUM_BW-1){1'b1}}};
        end else begin
            sum = wide[PSUM_BW-1:0];
        end
    end

    // Negative lanes are forced to zero.
    always_comb begin
        relu_out = relu_in[PSUM_BW-1] ? '0 : relu_in;
    end

endmodule

// File: rtl/sfu_accum.sv
// Accumulates ROWS psum vectors over NUM_PASS passes with saturation,
// applies ReLU, streams the rows into the OP SRAM and holds them on sfu_out.
module sfu_accum #(
    parameter int COL      = sfu_pkg::DEF_COL,
    parameter int PSUM_BW  = sfu_pkg::DEF_PSUM_BW,
    parameter int ROWS     = sfu_pkg::DEF_ROWS,
    parameter int NUM_PASS = sfu_pkg::DEF_NUM_PASS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [COL*PSUM_BW-1:0]         in_data,
    output logic                           op_cen,
    output logic                           op_wen,
    output logic [$clog2(ROWS)-1:0]        op_addr,
    output logic [COL*PSUM_BW-1:0]         op_d,
    output logic [ROWS*COL*PSUM_BW-1:0]    sfu_out,
    output logic                           sfu_done
);
    import sfu_pkg::*;

    localparam int VEC_W  = COL * PSUM_BW;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int PASS_W = $clog2(NUM_PASS);
    localparam int WR_W   = ROW_W + 1;

    sfu_state_t         state, state_n;
    logic [ROW_W-1:0]   row_cnt;
    logic [PASS_W-1:0]  pass_cnt;
    logic [WR_W-1:0]    wr_cnt;
    logic [ROW_W-1:0]   wr_idx;
    logic               beat, row_last, pass_last, wr_active;
    logic [VEC_W-1:0]   acc [ROWS];
    logic [VEC_W-1:0]   acc_sel, wr_sel, sum_vec, relu_vec;

    assign beat      = in_valid && in_ready;
    assign row_last  = (row_cnt == ROW_W'(ROWS - 1));
    assign pass_last = (pass_cnt == PASS_W'(NUM_PASS - 1));
    assign wr_idx    = wr_cnt[ROW_W-1:0];
    // wr_cnt runs one step past the last row so DONE and sfu_done land one edge after the final write.
    assign wr_active = (wr_cnt != WR_W'(ROWS));
    assign acc_sel   = acc[row_cnt];
    assign wr_sel    = acc[wr_idx];

    for (genvar c = 0; c < COL; c++) begin : g_lane
        sfu_lane #(.PSUM_BW(PSUM_BW)) u_lane (
            .acc      (acc_sel[c*PSUM_BW +: PSUM_BW]),
            .addend   (in_data[c*PSUM_BW +: PSUM_BW]),
            .sum      (sum_vec[c*PSUM_BW +: PSUM_BW]),
            .relu_in  (wr_sel[c*PSUM_BW +: PSUM_BW]),
            .relu_out (relu_vec[c*PSUM_BW +: PSUM_BW])
        );
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign sfu_out[r*VEC_W +: VEC_W] = acc[r];
    end

    // Next-state selection; start is only honoured from IDLE or DONE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = CLEAR;
            CLEAR:      state_n = ACCUM;
            ACCUM:      if (beat && row_last && pass_last) state_n = WRITE;
            WRITE:      if (!wr_active) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    // Control registers, counters and the OP SRAM port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            row_cnt  <= '0;
            pass_cnt <= '0;
            wr_cnt   <= '0;
            in_ready <= 1'b0;
            sfu_done <= 1'b0;
            op_cen   <= 1'b1;
            op_wen   <= 1'b1;
            op_addr  <= '0;
            op_d     <= '0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == ACCUM);
            sfu_done <= (state_n == DONE);
            op_cen   <= 1'b1;
            op_wen   <= 1'b1;
            case (state)
                CLEAR: begin
                    row_cnt  <= '0;
                    pass_cnt <= '0;
                    wr_cnt   <= '0;
                end
                ACCUM: begin
                    if (beat) begin
                        if (row_last) begin
                            row_cnt  <= '0;
                            pass_cnt <= pass_last ? '0 : pass_cnt + PASS_W'(1);
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (wr_active) begin
                        op_cen  <= 1'b0;
                        op_wen  <= 1'b0;
                        op_addr <= wr_idx;
                        op_d    <= relu_vec;
                        wr_cnt  <= wr_cnt + WR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator file: cleared at run start, summed per beat, ReLU'd in place during WRITE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
        end else if (state == CLEAR) begin
            for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
        end else if (state == ACCUM && beat) begin
            acc[row_cnt] <= sum_vec;
        end else if (state == WRITE && wr_active) begin
            acc[wr_idx] <= relu_vec;
        end
    end

endmodule

// File: tb/tb_sfu_accum.sv
// Scoreboard bench for sfu_accum: stimulus pushes expected OP writes and
// final sfu_out images; a negedge monitor pops and compares them.
module tb_sfu_accum;
    import sfu_pkg::*;

    localparam int COL      = 8;
    localparam int PSUM_BW  = 16;
    localparam int ROWS     = 16;
    localparam int NUM_PASS = 9;
    localparam int VEC_W    = COL * PSUM_BW;
    localparam int OUT_W    = ROWS * VEC_W;

    typedef struct packed {
        logic [3:0]       addr;
        logic [VEC_W-1:0] data;
    } wr_t;

    logic              clk, reset, start, in_valid, in_ready;
    logic [VEC_W-1:0]  in_data;
    logic              op_cen, op_wen;
    logic [3:0]        op_addr;
    logic [VEC_W-1:0]  op_d;
    logic [OUT_W-1:0]  sfu_out;
    logic              sfu_done;

    int checks = 0;
    int errors = 0;

    wr_t              exp_wr[$];
    logic [OUT_W-1:0] exp_out[$];

    sfu_accum #(
        .COL(COL), .PSUM_BW(PSUM_BW), .ROWS(ROWS), .NUM_PASS(NUM_PASS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .op_cen(op_cen), .op_wen(op_wen),
        .op_addr(op_addr), .op_d(op_d), .sfu_out(sfu_out), .sfu_done(sfu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compares every OP SRAM write and each sfu_done rising edge against the queues.
    bit prev_wr = 0;
    bit done_q  = 0;
    int streak  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_wr = 0;
            done_q  = 0;
            streak  = 0;
        end else begin
            if (!op_cen) begin
                wr_t e;
                streak = prev_wr ? streak + 1 : 1;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL op_write unexpected addr=%0d d=%h required=none", op_addr, op_d);
                end else begin
                    e = exp_wr.pop_front();
                    if (op_addr !== e.addr || op_d !== e.data || op_wen !== 1'b0 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL op_write actual addr=%0d d=%h wen=%b rdy=%b required addr=%0d d=%h wen=0 rdy=0",
                                 op_addr, op_d, op_wen, in_ready, e.addr, e.data);
                    end
                end
            end
            if (sfu_done && !done_q) begin
                logic [OUT_W-1:0] eo;
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL sfu_done unexpected actual=1 required=0");
                end else begin
                    eo = exp_out.pop_front();
                    if (sfu_out !== eo) begin
                        errors++;
                        for (int r = 0; r < ROWS; r++) begin
                            if (sfu_out[r*VEC_W +: VEC_W] !== eo[r*VEC_W +: VEC_W]) begin
                                $display("FAIL sfu_out row %0d actual=%h required=%h",
                                         r, sfu_out[r*VEC_W +: VEC_W], eo[r*VEC_W +: VEC_W]);
                                break;
                            end
                        end
                    end
                end
                checks++;
                if (!prev_wr || streak != ROWS) begin
                    errors++;
                    $display("FAIL write_burst actual streak=%0d last_prev=%0d required streak=%0d last_prev=1",
                             streak, prev_wr, ROWS);
                end
            end
            prev_wr = !op_cen;
            done_q  = sfu_done;
        end
    end

    // One full run: push expectations, start, feed NUM_PASS*ROWS beats, wait for done.
    task automatic do_run(input logic [VEC_W-1:0] vec, input logic [VEC_W-1:0] expv,
                          input bit gaps, input bit keep_valid, input int start_at);
        int beats = 0;
        int cyc   = 0;
        int n     = 0;
        bit acc_b;
        wr_t w;
        for (int k = 0; k < ROWS; k++) begin
            w.addr = 4'(k);
            w.data = expv;
            exp_wr.push_back(w);
        end
        exp_out.push_back({ROWS{expv}});

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("clear_ready", in_ready, 0);
        chk("clear_done", sfu_done, 0);
        @(posedge clk); #1;
        chk("accum_ready", in_ready, 1);
        chk("accum_cleared", (sfu_out == '0), 1);

        while (beats < NUM_PASS * ROWS) begin
            in_valid = !(gaps && (cyc % 5 == 4));
            in_data  = vec;
            start    = (start_at >= 0 && beats == start_at);
            acc_b    = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_b) beats++;
            cyc++;
            if (cyc > 2000) begin
                errors++;
                $display("FAIL beat_timeout actual=%0d required=%0d", beats, NUM_PASS * ROWS);
                break;
            end
        end
        start = 1'b0;
        if (!keep_valid) in_valid = 1'b0;

        while (!sfu_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_latency", n, ROWS + 1);

        if (keep_valid) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("done_ready_low", in_ready, 0);
                chk("done_hold", (sfu_done == 1'b1 && sfu_out == {ROWS{expv}}), 1);
            end
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [VEC_W-1:0] v_one, v_4k, v_neg, v_mix, e_nine, e_sat, e_zero, e_mix;
        lane_t l;
        int beats;
        bit acc_b;
        v_one  = {COL{16'h0001}};
        v_4k   = {COL{16'h4000}};
        v_neg  = {COL{16'hFFFF}};
        v_mix  = 128'h0003_0002_0001_0000_FFFF_FFFE_FFFD_FFFC;
        e_nine = {COL{16'h0009}};
        e_sat  = {COL{16'h7FFF}};
        e_zero = '0;
        e_mix  = 128'h001B_0012_0009_0000_0000_0000_0000_0000;

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_cen", op_cen, 1);
        chk("rst_wen", op_wen, 1);
        chk("rst_addr", op_addr, 0);
        chk("rst_d", op_d, 0);
        chk("rst_out_zero", (sfu_out == '0), 1);
        chk("rst_done", sfu_done, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 0);

        do_run(v_one, e_nine, 0, 0, -1);
        do_run(v_4k,  e_sat,  1, 0, -1);
        do_run(v_neg, e_zero, 0, 0, -1);
        do_run(v_mix, e_mix,  1, 0, -1);
        do_run(v_one, e_nine, 0, 1, 50);

        // Partial run aborted by reset after 20 beats.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0;
        for (int i = 0; i < 200 && beats < 20; i++) begin
            in_valid = 1'b1;
            in_data  = v_one;
            acc_b    = in_ready;
            @(posedge clk); #1;
            if (acc_b) beats++;
        end
        l = lane_t'(sfu_out[PSUM_BW-1:0]);
        chk("partial_row0", l, 16'h0002);
        reset = 1'b0;
        #1;
        chk("async_ready", in_ready, 0);
        chk("async_cen", op_cen, 1);
        chk("async_out_zero", (sfu_out == '0), 1);
        chk("async_done", sfu_done, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_run(v_one, e_nine, 0, 0, -1);

        repeat (4) @(posedge clk);
        #1;
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
